// File: rtl/montgomery_pkg.sv
// Shared types and helpers for the Montgomery constant generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package montgomery_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    R2   = 3'd2,
    NINV = 3'd3,
    DONE = 3'd4
  } state_e;

  // Argument width of msb_len; the generator supports DATA_WIDTH up to this.
  localparam int MSB_ARG_W = 64;

  // Width needed to hold a bit length in the range 0..w.
  function automatic int kw_of(input int w);
    return $clog2(w + 1);
  endfunction

  // Bit length of n: index of the most significant set bit plus one (0 for n == 0).
  function automatic int msb_len(input logic [MSB_ARG_W-1:0] n);
    int len;
    len = 0;
    for (int i = 0; i < MSB_ARG_W; i++) begin
      if (n[i]) len = i + 1;
    end
    return len;
  endfunction

endpackage

// File: rtl/mod_doubler.sv
// Modular doubling step: y = (2x >= n) ? 2x - n : 2x, valid for x < n.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module mod_doubler #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0] n,
  output logic [DATA_WIDTH-1:0] y
);

  logic [DATA_WIDTH:0] x2;

  // Double with one extra bit so the carry takes part in the compare.
  always_comb begin
    x2 = {x, 1'b0};
    if (x2 >= {1'b0, n}) y = DATA_WIDTH'(x2 - {1'b0, n});
    else                 y = x2[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/montgomery_precompute.sv
// Montgomery constants from odd modulus N: k, R mod N, R^2 mod N, optional N' (MONTGOMERY_NPRIME_EN).
// Latency: done after 1 edge on error, k+1 edges normally, 2k edges with N' enabled.
// Backpressure: none; a new start aborts the running job, results hold while done is high.
module montgomery_precompute
  import montgomery_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int KW         = kw_of(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] modulant,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [KW-1:0]         k_bits,
  output logic [DATA_WIDTH-1:0] R_mod,
  output logic [DATA_WIDTH-1:0] R_square,
  output logic [DATA_WIDTH-1:0] n_prime
);

  localparam int W = DATA_WIDTH;

  state_e         state_q, state_d;
  logic [W-1:0]   n_q, n_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   r_mod_q, r_mod_d;
  logic [W-1:0]   r_sq_q, r_sq_d;
  logic [KW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  k_q, k_d;
  logic           err_q, err_d;

  logic [KW-1:0]  k_load;
  logic [W-1:0]   r_mod_load;
  logic           n_bad;
  logic           r2_last;
  logic [W-1:0]   dbl_x;

`ifdef MONTGOMERY_NPRIME_EN
  logic [W-1:0]   inv_q, inv_d;
  logic [W-1:0]   t_q, t_d;
  logic [KW-1:0]  i_q, i_d;
  logic [W-1:0]   np_q, np_d;
  logic           t_bit;
  logic [W-1:0]   inv_nxt, t_nxt, k_mask, np_final;
  logic           ninv_last;
`endif

  mod_doubler #(.DATA_WIDTH(W)) u_doubler (
    .x (x_q),
    .n (n_q),
    .y (dbl_x)
  );

  // LOAD-time constants and loop terminations derived from the latched modulus.
  always_comb begin
    k_load     = KW'(msb_len(MSB_ARG_W'(n_q)));
    // 2^(k-1) <= N < 2^k, so 2^k - N always fits in W bits.
    r_mod_load = W'(({{W{1'b0}}, 1'b1} << k_load) - {1'b0, n_q});
    n_bad      = ~n_q[0] | (n_q < W'(3));
    r2_last    = (cnt_q == KW'(1));
  end

`ifdef MONTGOMERY_NPRIME_EN
  // One Hensel-lifting step of the inverse per cycle, bit i_q of the running product.
  always_comb begin
    t_bit     = |(t_q & (W'(1) << i_q));
    inv_nxt   = t_bit ? (inv_q | (W'(1) << i_q)) : inv_q;
    t_nxt     = t_bit ? (t_q + (n_q << i_q)) : t_q;
    k_mask    = W'(({{W{1'b0}}, 1'b1} << k_q) - (W+1)'(1));
    np_final  = (~inv_nxt + W'(1)) & k_mask;
    ninv_last = (i_q == k_q - KW'(1));
  end
`endif

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      x_q     <= '0;
      r_mod_q <= '0;
      r_sq_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
`ifdef MONTGOMERY_NPRIME_EN
      inv_q   <= '0;
      t_q     <= '0;
      i_q     <= '0;
      np_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      x_q     <= x_d;
      r_mod_q <= r_mod_d;
      r_sq_q  <= r_sq_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      err_q   <= err_d;
`ifdef MONTGOMERY_NPRIME_EN
      inv_q   <= inv_d;
      t_q     <= t_d;
      i_q     <= i_d;
      np_q    <= np_d;
`endif
    end
  end

  // Next state: start always restarts at LOAD, otherwise walk LOAD -> R2 (-> NINV) -> DONE.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        LOAD: state_d = n_bad ? DONE : R2;
`ifdef MONTGOMERY_NPRIME_EN
        R2:   if (r2_last) state_d = NINV;
        NINV: if (ninv_last) state_d = DONE;
`else
        R2:   if (r2_last) state_d = DONE;
`endif
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath updates; result registers change only when their state is left.
  always_comb begin
    n_d     = n_q;
    x_d     = x_q;
    r_mod_d = r_mod_q;
    r_sq_d  = r_sq_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    err_d   = err_q;
`ifdef MONTGOMERY_NPRIME_EN
    inv_d   = inv_q;
    t_d     = t_q;
    i_d     = i_q;
    np_d    = np_q;
`endif
    if (start) begin
      n_d     = modulant;
      x_d     = '0;
      r_mod_d = '0;
      r_sq_d  = '0;
      cnt_d   = '0;
      k_d     = '0;
      err_d   = 1'b0;
`ifdef MONTGOMERY_NPRIME_EN
      np_d    = '0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          if (n_bad) begin
            err_d = 1'b1;
          end else begin
            k_d     = k_load;
            r_mod_d = r_mod_load;
            x_d     = r_mod_load;
            cnt_d   = k_load;
          end
        end
        R2: begin
          x_d   = dbl_x;
          cnt_d = cnt_q - KW'(1);
          if (r2_last) begin
            r_sq_d = dbl_x;
`ifdef MONTGOMERY_NPRIME_EN
            inv_d  = W'(1);
            t_d    = n_q;
            i_d    = KW'(1);
`endif
          end
        end
`ifdef MONTGOMERY_NPRIME_EN
        NINV: begin
          inv_d = inv_nxt;
          t_d   = t_nxt;
          i_d   = i_q + KW'(1);
          if (ninv_last) np_d = np_final;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Status decode from the current state.
  always_comb begin
    busy = (state_q == LOAD) || (state_q == R2) || (state_q == NINV);
    done = (state_q == DONE);
  end

  assign error    = err_q;
  assign k_bits   = k_q;
  assign R_mod    = r_mod_q;
  assign R_square = r_sq_q;
`ifdef MONTGOMERY_NPRIME_EN
  assign n_prime  = np_q;
`else
  assign n_prime  = '0;
`endif

endmodule

// File: tb/tb_montgomery_precompute.sv
// Bench for montgomery_precompute: scoreboard of reference-model results, checked on each done.
// Latency: checked per job against the expected edge count.
// Backpressure: none; jobs are issued one at a time, plus abort and reset cases.
module tb_montgomery_precompute;

  localparam int W  = 8;
  localparam int KW = $clog2(W + 1);
`ifdef MONTGOMERY_NPRIME_EN
  localparam bit NP_EN = 1'b1;
`else
  localparam bit NP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  modulant = '0;
  logic          busy, done, error;
  logic [KW-1:0] k_bits;
  logic [W-1:0]  R_mod, R_square, n_prime;

  typedef struct {
    int n;
    int k;
    int rmod;
    int rsq;
    int np;
    bit err;
    int lat;
    int start_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  bit   done_prev = 1'b0;
  logic [KW+3*W:0] held;

  montgomery_precompute #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .modulant (modulant),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .k_bits   (k_bits),
    .R_mod    (R_mod),
    .R_square (R_square),
    .n_prime  (n_prime)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain modular arithmetic and a brute-force inverse search.
  function automatic exp_t model(input int n, input int start_edge);
    exp_t  e;
    longint r;
    e.n = n; e.k = 0; e.rmod = 0; e.rsq = 0; e.np = 0;
    e.start_edge = start_edge;
    e.err = (n % 2 == 0) || (n < 3);
    if (e.err) begin
      e.lat = 1;
    end else begin
      e.k    = $clog2(n + 1);
      r      = longint'(1) << e.k;
      e.rmod = int'(r % n);
      e.rsq  = int'((r * r) % n);
      if (NP_EN) begin
        for (longint x = 1; x < r; x += 2)
          if ((longint'(n) * x) % r == 1) e.np = int'((r - x) % r);
      end
      e.lat  = NP_EN ? 2 * e.k : e.k + 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per rising done; verifies hold while done stays high.
  always @(negedge clk) begin
    exp_t e;
    if (start) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (busy && done) chk("busy_done_exclusive", 1, 0);
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("latency n=%0d", e.n), cyc - e.start_edge, e.lat);
        chk($sformatf("busy_cycles n=%0d", e.n), busy_cnt, e.lat);
        chk($sformatf("error n=%0d", e.n), error, e.err);
        if (!e.err) chk($sformatf("k n=%0d", e.n), k_bits, e.k);
        chk($sformatf("r_mod n=%0d", e.n), R_mod, e.rmod);
        chk($sformatf("r_square n=%0d", e.n), R_square, e.rsq);
        chk($sformatf("n_prime n=%0d", e.n), n_prime, e.np);
      end
      held = {error, k_bits, R_mod, R_square, n_prime};
    end else if (done && done_prev) begin
      chk("results_hold", {error, k_bits, R_mod, R_square, n_prime}, held);
    end
    done_prev = done;
  end

  // Caller sits just after a rising edge; start is sampled on the next edge.
  task automatic issue(input int n, input bit track);
    start    = 1'b1;
    modulant = W'(n);
    if (track) exp_q.push_back(model(n, cyc + 1));
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q.size() != 0 && n < 200);
    #1;
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_results"}, {k_bits, R_mod, R_square, n_prime}, 0);
  endtask

  initial begin
    int dir [6] = '{13, 255, 3, 12, 1, 0};
    int l13;
    int n;
    l13 = NP_EN ? 8 : 5;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (dir[i]) begin
      issue(dir[i], 1'b1);
      wait_idle();
    end

    // Abort: second start during R2 replaces the first job.
    issue(13, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    issue(255, 1'b1);
    wait_idle();

    // Start on the very edge that would enter DONE: done must not appear.
    issue(13, 1'b0);
    repeat (l13 - 1) @(posedge clk);
    #1;
    issue(3, 1'b1);
    chk("done_suppressed_by_start", done, 0);
    wait_idle();

    // Reset in the middle of R2, then a clean job.
    issue(13, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_in_r2", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_cleared("midreset");
    issue(13, 1'b1);
    wait_idle();

    // Randomised moduli, mostly odd.
    repeat (40) begin
      n = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) n = n | 1;
      issue(n, 1'b1);
      wait_idle();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
